control_sequencer: RTL and testbench

- Instruction register plus microcoded control unit for the 8-bit bus computer.
- Latches the fetched instruction from the shared bus and steps a T-state counter.
- Decodes {opcode, step, flags} into the control word that sequences the program counter, RAM/MAR, A/B/ALU and output register.
- Holds the carry/zero flags used by conditional jumps and latches halt.

---
 rtl/control_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Instruction register and microcoded control unit for the
//               8-bit bus computer. Latches the fetched instruction, steps
//               the T-state counter, and decodes {opcode, step, flags} into
//               the control word. It also holds the carry/zero flags and the
//               halt latch.
//               Optional build macro SEQ_EARLY_FETCH_EN: when defined, each
//               instruction returns to T0 right after its last useful
//               microstep instead of always running all NUM_STEPS states.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int DATA_W    = 8,
    parameter int NUM_STEPS = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic              MI,
    output logic              RI,
    output logic              RO,
    output logic              HLT,
    output logic              CO,
    output logic              J,
    output logic              CE,
    output logic              AI,
    output logic              AO,
    output logic              EO,
    output logic              SU,
    output logic              BI,
    output logic              OI,
    output logic              II,
    output logic              IO,
    output logic              FI,
    output logic [2:0]        step,
    output logic [3:0]        opcode,
    output logic              halted
);

    localparam int         C_OP_W     = 4;
    localparam int         C_ARG_W    = DATA_W - C_OP_W;
    localparam logic [2:0] C_STEP_MAX = 3'(NUM_STEPS - 1);

    localparam logic [3:0] C_OP_LDA = 4'h1;
    localparam logic [3:0] C_OP_ADD = 4'h2;
    localparam logic [3:0] C_OP_SUB = 4'h3;
    localparam logic [3:0] C_OP_STA = 4'h4;
    localparam logic [3:0] C_OP_LDI = 4'h5;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_JC  = 4'h7;
    localparam logic [3:0] C_OP_JZ  = 4'h8;
    localparam logic [3:0] C_OP_OUT = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    logic [DATA_W-1:0] r_ir;
    logic [2:0]        r_step;
    logic              r_carry;
    logic              r_zero;
    logic              r_halted;

    logic [3:0]        w_op;
    logic [2:0]        w_last_step;
    logic              w_wrap;
    logic              w_run;
    logic w_mi, w_ri, w_ro, w_hlt, w_co, w_j, w_ce, w_ai;
    logic w_ao, w_eo, w_su, w_bi, w_oi, w_ii, w_io, w_fi;

    assign w_op = r_ir[DATA_W-1 -: C_OP_W];

    // Microcode ROM: raw control word for the current opcode, step and flags
    always_comb begin
        w_mi = 1'b0; w_ri = 1'b0; w_ro = 1'b0; w_hlt = 1'b0;
        w_co = 1'b0; w_j  = 1'b0; w_ce = 1'b0; w_ai  = 1'b0;
        w_ao = 1'b0; w_eo = 1'b0; w_su = 1'b0; w_bi  = 1'b0;
        w_oi = 1'b0; w_ii = 1'b0; w_io = 1'b0; w_fi  = 1'b0;
        case (r_step)
            3'd0: begin
                w_co = 1'b1;
                w_mi = 1'b1;
            end
            3'd1: begin
                w_ro = 1'b1;
                w_ii = 1'b1;
                w_ce = 1'b1;
            end
            3'd2: begin
                case (w_op)
                    C_OP_LDA, C_OP_ADD, C_OP_SUB, C_OP_STA: begin
                        w_io = 1'b1;
                        w_mi = 1'b1;
                    end
                    C_OP_LDI: begin
                        w_io = 1'b1;
                        w_ai = 1'b1;
                    end
                    C_OP_JMP: begin
                        w_io = 1'b1;
                        w_j  = 1'b1;
                    end
                    C_OP_JC: begin
                        w_io = r_carry;
                        w_j  = r_carry;
                    end
                    C_OP_JZ: begin
                        w_io = r_zero;
                        w_j  = r_zero;
                    end
                    C_OP_OUT: begin
                        w_ao = 1'b1;
                        w_oi = 1'b1;
                    end
                    C_OP_HLT: w_hlt = 1'b1;
                    default: ;
                endcase
            end
            3'd3: begin
                case (w_op)
                    C_OP_LDA: begin
                        w_ro = 1'b1;
                        w_ai = 1'b1;
                    end
                    C_OP_ADD, C_OP_SUB: begin
                        w_ro = 1'b1;
                        w_bi = 1'b1;
                    end
                    C_OP_STA: begin
                        w_ao = 1'b1;
                        w_ri = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                if (w_op == C_OP_ADD || w_op == C_OP_SUB) begin
                    w_eo = 1'b1;
                    w_ai = 1'b1;
                    w_fi = 1'b1;
                    w_su = (w_op == C_OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // Final microstep of the current instruction
`ifdef SEQ_EARLY_FETCH_EN
    // Every opcode has a meaningful T2 decision (or is empty), so the earliest
    // end is T2; by then the IR holds the new opcode.
    always_comb begin
        w_last_step = 3'd2;
        case (w_op)
            C_OP_LDA, C_OP_STA: w_last_step = 3'd3;
            C_OP_ADD, C_OP_SUB: w_last_step = 3'd4;
            default: ;
        endcase
    end
`else
    assign w_last_step = C_STEP_MAX;
`endif

    assign w_wrap = (r_step == w_last_step) || (r_step == C_STEP_MAX);

    // Outputs are silenced during reset; when halted only HLT stays asserted
    assign w_run = reset_n & ~r_halted;
    assign MI  = w_run & w_mi;
    assign RI  = w_run & w_ri;
    assign RO  = w_run & w_ro;
    assign HLT = reset_n & (r_halted | w_hlt);
    assign CO  = w_run & w_co;
    assign J   = w_run & w_j;
    assign CE  = w_run & w_ce;
    assign AI  = w_run & w_ai;
    assign AO  = w_run & w_ao;
    assign EO  = w_run & w_eo;
    assign SU  = w_run & w_su;
    assign BI  = w_run & w_bi;
    assign OI  = w_run & w_oi;
    assign II  = w_run & w_ii;
    assign IO  = w_run & w_io;
    assign FI  = w_run & w_fi;

    // Only the operand field is placed on the bus; the opcode nibble reads 0
    assign bus = IO ? {{C_OP_W{1'b0}}, r_ir[C_ARG_W-1:0]} : {DATA_W{1'bz}};

    assign step   = r_step;
    assign opcode = w_op;
    assign halted = r_halted;

    // T-state counter; holds while a halt is being taken or is latched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step <= 3'd0;
        end else if (!HLT) begin
            r_step <= w_wrap ? 3'd0 : r_step + 3'd1;
        end
    end

    // Instruction register loads the whole bus word during fetch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= '0;
        end else if (II) begin
            r_ir <= bus;
        end
    end

    // Flags captured from the ALU only when FI is asserted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (FI) begin
            r_carry <= carry_in;
            r_zero  <= zero_in;
        end
    end

    // Halt latch, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_halted <= 1'b0;
        end else if (HLT) begin
            r_halted <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A stimulus process
//               plays the role of memory/ALU, predicts every cycle from the
//               instruction-level rules and queues the expectation; a monitor
//               pops and compares once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int DATA_W    = 8;
    localparam int NUM_STEPS = 5;

    // Control word bit positions: {MI,RI,RO,HLT,CO,J,CE,AI,AO,EO,SU,BI,OI,II,IO,FI}
    localparam logic [15:0] M_MI  = 16'h8000;
    localparam logic [15:0] M_RI  = 16'h4000;
    localparam logic [15:0] M_RO  = 16'h2000;
    localparam logic [15:0] M_HLT = 16'h1000;
    localparam logic [15:0] M_CO  = 16'h0800;
    localparam logic [15:0] M_J   = 16'h0400;
    localparam logic [15:0] M_CE  = 16'h0200;
    localparam logic [15:0] M_AI  = 16'h0100;
    localparam logic [15:0] M_AO  = 16'h0080;
    localparam logic [15:0] M_EO  = 16'h0040;
    localparam logic [15:0] M_SU  = 16'h0020;
    localparam logic [15:0] M_BI  = 16'h0010;
    localparam logic [15:0] M_OI  = 16'h0008;
    localparam logic [15:0] M_II  = 16'h0004;
    localparam logic [15:0] M_IO  = 16'h0002;
    localparam logic [15:0] M_FI  = 16'h0001;

    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic carry_in = 1'b0;
    logic zero_in  = 1'b0;
    logic       tb_drv_en  = 1'b0;
    logic [7:0] tb_drv_val = 8'h00;
    wire  [7:0] bus;

    logic MI, RI, RO, HLT, CO, J, CE, AI, AO, EO, SU, BI, OI, II, IO, FI;
    logic [2:0] step;
    logic [3:0] opcode;
    logic       halted;

    assign bus = tb_drv_en ? tb_drv_val : 8'bz;

    always #5 clock = ~clock;

    control_sequencer #(
        .DATA_W   (DATA_W),
        .NUM_STEPS(NUM_STEPS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .carry_in(carry_in),
        .zero_in (zero_in),
        .MI(MI), .RI(RI), .RO(RO), .HLT(HLT), .CO(CO), .J(J), .CE(CE), .AI(AI),
        .AO(AO), .EO(EO), .SU(SU), .BI(BI), .OI(OI), .II(II), .IO(IO), .FI(FI),
        .step    (step),
        .opcode  (opcode),
        .halted  (halted)
    );

    typedef struct packed {
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic [3:0]  op;
        logic        halted;
        logic [7:0]  bus;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state at instruction level
    logic [7:0] m_ir    = 8'h00;
    logic       m_carry = 1'b0;
    logic       m_zero  = 1'b0;

    // Microprogram table for one instruction
    function automatic logic [15:0] ucode(input logic [3:0] op, input int t,
                                          input logic c, input logic z);
        logic [15:0] w;
        w = '0;
        if (t == 0) w = M_CO | M_MI;
        else if (t == 1) w = M_RO | M_II | M_CE;
        else if (t == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: w = M_IO | M_MI;
                4'h5: w = M_IO | M_AI;
                4'h6: w = M_IO | M_J;
                4'h7: w = c ? (M_IO | M_J) : 16'h0000;
                4'h8: w = z ? (M_IO | M_J) : 16'h0000;
                4'hE: w = M_AO | M_OI;
                4'hF: w = M_HLT;
                default: w = '0;
            endcase
        end else if (t == 3) begin
            case (op)
                4'h1: w = M_RO | M_AI;
                4'h2, 4'h3: w = M_RO | M_BI;
                4'h4: w = M_AO | M_RI;
                default: w = '0;
            endcase
        end else if (t == 4) begin
            case (op)
                4'h2: w = M_EO | M_AI | M_FI;
                4'h3: w = M_EO | M_AI | M_FI | M_SU;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // Cycles an instruction occupies
    function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_EARLY_FETCH_EN
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
`else
        return (op == 4'h0) ? NUM_STEPS : NUM_STEPS;
`endif
    endfunction

    task automatic set_flags(input int mode);
        if (mode < 0) begin
            carry_in = 1'($urandom);
            zero_in  = 1'($urandom);
        end else begin
            carry_in = mode[1];
            zero_in  = mode[0];
        end
    endtask

    task automatic push_exp(input logic [15:0] ctrl, input logic [2:0] st,
                            input logic [3:0] op, input logic h, input logic [7:0] b);
        exp_t e;
        e.ctrl   = ctrl;
        e.step   = st;
        e.op     = op;
        e.halted = h;
        e.bus    = b;
        sb_q.push_back(e);
    endtask

    // Assert reset for the cycle that starts at the current falling edge
    task automatic reset_pulse();
        reset_n    = 1'b0;
        m_ir       = 8'h00;
        m_carry    = 1'b0;
        m_zero     = 1'b0;
        set_flags(-1);
        tb_drv_en  = 1'b1;
        tb_drv_val = 8'($urandom);
        push_exp(16'h0000, 3'd0, 4'h0, 1'b0, tb_drv_val);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            set_flags(-1);
            tb_drv_en  = 1'b1;
            tb_drv_val = 8'($urandom);
            push_exp(M_HLT, 3'd2, m_ir[7:4], 1'b1, tb_drv_val);
        end
        @(negedge clock);
        reset_pulse();
    endtask

    // Play one instruction; abort_at >= 0 resets the block at that step
    task automatic run_instr(input logic [7:0] instr, input int flag_mode, input int abort_at);
        int          len;
        logic [15:0] w;
        logic [7:0]  b;
        len = instr_len(instr[7:4]);
        for (int t = 0; t < len; t++) begin
            @(negedge clock);
            if (t == abort_at) begin
                reset_pulse();
                return;
            end
            reset_n = 1'b1;
            set_flags(flag_mode);
            w = ucode(m_ir[7:4], t, m_carry, m_zero);
            if ((w & M_IO) != 16'h0000) begin
                tb_drv_en = 1'b0;
                b = {4'h0, m_ir[3:0]};
            end else begin
                tb_drv_en  = 1'b1;
                tb_drv_val = (t == 1) ? instr : 8'($urandom);
                b = tb_drv_val;
            end
            push_exp(w, 3'(t), m_ir[7:4], 1'b0, b);
            if ((w & M_II) != 16'h0000) m_ir = instr;
            if ((w & M_FI) != 16'h0000) begin
                m_carry = carry_in;
                m_zero  = zero_in;
            end
            if ((w & M_HLT) != 16'h0000) begin
                halt_cycles(10);
                return;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: one comparison set per cycle, away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctrl", {MI, RI, RO, HLT, CO, J, CE, AI, AO, EO, SU, BI, OI, II, IO, FI}, e.ctrl);
                check("step", 16'(step), 16'(e.step));
                check("opcode", 16'(opcode), 16'(e.op));
                check("halted", 16'(halted), 16'(e.halted));
                check("bus", 16'(bus), 16'(e.bus));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        logic [7:0] instr;
        int         ab;
        @(negedge clock);
        reset_pulse();
        run_instr(8'h1C, -1, 3);     // LDA abandoned in T3 by reset
        run_instr(8'h57, -1, -1);    // LDI, operand 7 on bus at T2
        run_instr(8'h2A, 2, -1);     // ADD with carry=1 zero=0 captured at T4
        run_instr(8'h73, -1, -1);    // JC taken
        run_instr(8'h3B, 1, -1);     // SUB leaves carry=0 zero=1
        run_instr(8'h73, -1, -1);    // JC not taken
        run_instr(8'h8F, -1, -1);    // JZ taken
        run_instr(8'h4D, -1, -1);    // STA
        run_instr(8'hE0, -1, -1);    // OUT
        run_instr(8'h00, -1, -1);    // NOP
        run_instr(8'h9C, -1, -1);    // unused opcode
        run_instr(8'hF0, -1, -1);    // HLT, ten halted cycles, then reset
        for (int n = 0; n < 250; n++) begin
            instr = 8'($urandom);
            if (instr[7:4] == 4'hF && $urandom_range(0, 3) != 0) instr[7:4] = 4'h6;
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, instr_len(instr[7:4]) - 1)) : -1;
            run_instr(instr, -1, ab);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
